mul_seq: RTL
============

# mul_seq

Multi-cycle 16x16 multiply sequencer that borrows the shared ALU's adder. It computes the low 16 bits of an unsigned (equivalently two's-complement) product by shift-and-add. It sits beside the execute stage. The execute stage keeps priority on the ALU, and the sequencer only uses the adder in cycles where it is granted. Shifting is done in local registers; the ALU performs every accumulate.

## Interface
Parameters: none.

- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  request a multiply; sampled only in IDLE
- opA  in  16  multiplicand; captured when start is accepted
- opB  in  16  multiplier; captured when start is accepted
- busy  out  1  high in RUN
- done  out  1  one-cycle pulse; product valid
- product  out  16  low 16 bits of opA*opB; holds until the next accepted start
- aluReq  out  1  sequencer needs the adder this cycle
- aluGrant  in  1  ALU inputs are driven from this block this cycle (arbiter/decode owned)
- aluSrc1  out  16  multiplicand register (mcand)
- aluSrc2  out  16  accumulator register (acc)
- aluOp  out  3  constant 3'b110 (ADD, src1+src2)
- aluResult  in  16  ALU output; combinational, same cycle

## Operation
- Registers:
  - state in {IDLE, RUN, DONE}
  - mcand[15:0], mplier[15:0], acc[15:0]
  - product is acc.
- IDLE:
  - If start=1: mcand<=opA, mplier<=opB, acc<=0, go to RUN.
  - Otherwise hold all registers.
- RUN, evaluated in priority order:
  - If mplier==0: go to DONE; no register change.
  - Else if mplier[0]==1 and aluGrant==1: acc<=aluResult, mcand<=mcand<<1, mplier<=mplier>>1 (logical).
  - Else if mplier[0]==1 and aluGrant==0: stall; hold all registers and state.
  - Else (mplier[0]==0): mcand<=mcand<<1, mplier<=mplier>>1; ALU not used.
- DONE: done=1 for exactly this cycle, then go to IDLE.
- start is ignored in RUN and DONE. It is not queued.
- aluReq = (state==RUN) & (mplier!=0) & mplier[0]. aluReq is combinational from registers only, never from aluGrant.
- Arithmetic width and overflow:
  - All arithmetic is modulo 2^16; carries out of the adder and bits shifted out of mcand are discarded.
  - The result equals the low half of both signed and unsigned products.
- aluGrant is don't-care when aluReq=0. Grant without request causes no state change.
- Reset, including mid-operation: state<=IDLE; acc, mcand, mplier <= 0; done=0, busy=0, aluReq=0. Any in-flight multiply is abandoned with no done pulse.

## Timing
- Reset values: busy=0, done=0, product=0, aluReq=0, aluSrc1=0, aluSrc2=0, aluOp=3'b110.
- Start accepted at edge E: busy=1 from cycle E+1.
- RUN duration = (position of the highest set bit of opB)+1 iterations, plus one zero-check cycle, plus stall cycles.
  - Maximum 17 cycles with continuous grant (opB=0xFFFF).
  - opB=0: one RUN cycle.
- done is high in the cycle right after the last RUN cycle; busy is low in that cycle. The earliest next start is accepted on the cycle after done.
- With continuous grant, latency from the start edge to the done cycle is N+2 cycles, where N = number of shift iterations.
- aluResult must settle within the same cycle. No pipelining of the ALU path.

## Test plan
- Reset, then opA=3, opB=5, start for 1 cycle, aluGrant=1 held:
  - RUN lasts 4 cycles, aluReq high in RUN cycles 1 and 3.
  - done pulses once in the 5th cycle after the start edge, product=15.
- opA=300, opB=300, grant=1 -> product=0x5F90 (90000 mod 2^16).
- opA=0xFFFF, opB=0xFFFF -> product=0x0001 after 17 RUN cycles.
- opA=0x1234, opB=0 -> one RUN cycle, aluReq never high, done with product=0.
- opA=7, opB=3, aluGrant=0 for 4 cycles after the first aluReq, then 1:
  - Registers frozen during the stall.
  - aluReq stays high throughout the stall.
  - product=21; done occurs 4 cycles later than the no-stall run.
- Robustness:
  - Start pulses during RUN and DONE are ignored; the product is unchanged.
  - rst asserted in the 3rd RUN cycle: next cycle busy=0, product=0, no done pulse.
  - A new start then completes normally.

Source files
------------

// File: rtl/mul_seq.sv
// Shift-and-add 16x16 multiplier (low 16 bits of the product) that borrows the
// shared ALU adder only in cycles where the execute stage grants it.
module mul_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] opA,
    input  logic [15:0] opB,
    output logic        busy,
    output logic        done,
    output logic [15:0] product,
    output logic        aluReq,
    input  logic        aluGrant,
    output logic [15:0] aluSrc1,
    output logic [15:0] aluSrc2,
    output logic [2:0]  aluOp,
    input  logic [15:0] aluResult
);

    localparam logic [2:0] ALU_OP_ADD = 3'b110;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } stateT;

    stateT       stateReg;
    logic [15:0] mcandReg;
    logic [15:0] mplierReg;
    logic [15:0] accReg;
    logic        busyReg;
    logic        doneReg;

    always_ff @(posedge clk) begin
        if (rst) begin
            stateReg  <= IDLE;
            mcandReg  <= 16'd0;
            mplierReg <= 16'd0;
            accReg    <= 16'd0;
            busyReg   <= 1'b0;
            doneReg   <= 1'b0;
        end else begin
            case (stateReg)
                IDLE: begin
                    if (start) begin
                        mcandReg  <= opA;
                        mplierReg <= opB;
                        accReg    <= 16'd0;
                        busyReg   <= 1'b1;
                        stateReg  <= RUN;
                    end
                end
                RUN: begin
                    if (mplierReg == 16'd0) begin
                        busyReg  <= 1'b0;
                        doneReg  <= 1'b1;
                        stateReg <= DONE;
                    end else if (mplierReg[0]) begin
                        // Accumulate needs the adder; without a grant everything freezes.
                        if (aluGrant) begin
                            accReg    <= aluResult;
                            mcandReg  <= {mcandReg[14:0], 1'b0};
                            mplierReg <= {1'b0, mplierReg[15:1]};
                        end
                    end else begin
                        mcandReg  <= {mcandReg[14:0], 1'b0};
                        mplierReg <= {1'b0, mplierReg[15:1]};
                    end
                end
                DONE: begin
                    doneReg  <= 1'b0;
                    stateReg <= IDLE;
                end
                default: begin
                    busyReg  <= 1'b0;
                    doneReg  <= 1'b0;
                    stateReg <= IDLE;
                end
            endcase
        end
    end

    // Request depends on registered state only, so it never loops through the arbiter.
    assign aluReq  = (stateReg == RUN) & (mplierReg != 16'd0) & mplierReg[0];
    assign aluSrc1 = mcandReg;
    assign aluSrc2 = accReg;
    assign aluOp   = ALU_OP_ADD;
    assign product = accReg;
    assign busy    = busyReg;
    assign done    = doneReg;

endmodule
